alu_seq: RTL and testbench

Registered, parametrised successor to the 8-bit combinational ALU. It extends the 13-op set to any `WIDTH`, adds a persistent flag register, carry-chained ADC/SBC and an iterative unsigned multiplier. Operands enter and results leave through valid/ready handshakes. The block sits between the decode/operand-fetch stage and register writeback, and holds the architectural C/V/Z/N flags.

---
 rtl/alu_seq_if.sv | 37 +++
 rtl/alu_seq.sv | 201 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/result handshake bundle for alu_seq.
//   master : operand producer / result consumer (decode + writeback side)
//   slave  : the ALU itself
// Handshake rule (both channels): a transfer happens on a rising clk edge
// where valid and ready are both high. The source holds its payload stable
// while valid is high and ready is low. The sink may raise or lower ready
// freely; valid, once raised, stays high until the transfer.
//   in_valid/in_ready   : opcode, A, B from master to slave
//   out_valid/out_ready : result, result_hi, C/V/Z/N, illegal to master
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       opcode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             C;
  logic             V;
  logic             Z;
  logic             N;
  logic             illegal;

  modport master (
    output in_valid, opcode, A, B, out_ready,
    input  in_ready, out_valid, result, result_hi, C, V, Z, N, illegal
  );

  modport slave (
    input  in_valid, opcode, A, B, out_ready,
    output in_ready, out_valid, result, result_hi, C, V, Z, N, illegal
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with persistent C/V/Z/N flag register,
// carry-chained ADC/SBC and an optional shift-add unsigned multiplier.
// Ports:
//   clk     : clock, all state changes on its rising edge
//   rst     : synchronous active-high reset, aborts any op in flight
//   bus     : alu_seq_if slave modport (operand and result handshakes)
//   state_o : current FSM state (0 IDLE, 1 MUL, 2 DONE) for observation
module alu_seq #(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  alu_seq_if.slave   bus,
  output logic [1:0] state_o
);

  localparam int MSB = WIDTH - 1;
  localparam int CW  = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] result_hi_q;
  logic             c_q, v_q, z_q, n_q, ill_q;

  logic accept;
  logic is_mul;

  assign accept = bus.in_valid & (state_q == S_IDLE);
  assign is_mul = MUL_EN && (bus.opcode == 8'h0F);

  // ---------------------------------------------------------------
  // Single-cycle datapath, evaluated on the operands at accept time.
  // ADD/ADC share one adder and SUB/SBC/SLT share one subtractor; the
  // flag carry only feeds in for ADC and SBC.
  // ---------------------------------------------------------------
  logic             add_cin, sub_bin;
  logic [WIDTH:0]   add_w, sub_w, inc_w, dec_w;
  logic             add_v, sub_v;
  logic [WIDTH-1:0] alu_r;
  logic             alu_c, alu_v, alu_ill;

  always_comb begin
    add_cin = (bus.opcode == 8'h0D) & c_q;
    sub_bin = (bus.opcode == 8'h0E) & c_q;
    add_w   = {1'b0, bus.A} + {1'b0, bus.B} + {{WIDTH{1'b0}}, add_cin};
    sub_w   = {1'b0, bus.A} - {1'b0, bus.B} - {{WIDTH{1'b0}}, sub_bin};
    inc_w   = {1'b0, bus.B} + {{WIDTH{1'b0}}, 1'b1};
    dec_w   = {1'b0, bus.B} - {{WIDTH{1'b0}}, 1'b1};
    // Signed overflow: the carry-in/borrow-in does not change the rule.
    add_v   = (bus.A[MSB] == bus.B[MSB]) & (add_w[MSB] != bus.A[MSB]);
    sub_v   = (bus.A[MSB] != bus.B[MSB]) & (sub_w[MSB] != bus.A[MSB]);

    alu_r   = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (bus.opcode)
      8'h00, 8'h0D: begin alu_r = add_w[MSB:0]; alu_c = add_w[WIDTH]; alu_v = add_v; end
      8'h01, 8'h0E: begin alu_r = sub_w[MSB:0]; alu_c = sub_w[WIDTH]; alu_v = sub_v; end
      8'h02: alu_r = bus.A & bus.B;
      8'h03: alu_r = bus.A | bus.B;
      8'h04: alu_r = bus.A ^ bus.B;
      // Signed less-than is N xor V of A-B.
      8'h05: alu_r = {{(WIDTH-1){1'b0}}, sub_w[MSB] ^ sub_v};
      8'h06: begin
        alu_r = inc_w[MSB:0];
        alu_c = inc_w[WIDTH];
        alu_v = ~bus.B[MSB] & inc_w[MSB];
      end
      8'h07: begin
        alu_r = dec_w[MSB:0];
        alu_c = dec_w[WIDTH];
        alu_v = bus.B[MSB] & ~dec_w[MSB];
      end
      8'h08: begin alu_r = {bus.B[MSB-1:0], 1'b0};      alu_c = bus.B[MSB]; end
      8'h09: begin alu_r = {1'b0, bus.B[MSB:1]};        alu_c = bus.B[0];   end
      8'h0A: begin alu_r = {bus.B[MSB], bus.B[MSB:1]};  alu_c = bus.B[0];   end
      8'h0B: alu_r = {bus.B[MSB-1:0], bus.B[MSB]};
      8'h0C: alu_r = {bus.B[0], bus.B[MSB:1]};
      // 0x0F lands here only when the multiplier is not built.
      default: alu_ill = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------
  // Shift-add multiplier: {hi,lo} starts as {0,A}; each MUL cycle adds
  // the multiplicand to hi when lo[0] is set, then shifts {carry,hi,lo}
  // right by one. The WIDTH-th step is committed straight to the result
  // registers so the partial product never reaches the outputs.
  // ---------------------------------------------------------------
  logic [WIDTH-1:0] mul_hi_d, mul_lo_d;
  logic             mul_last;

  if (MUL_EN) begin : g_mul
    logic [WIDTH-1:0] mc_q, hi_q, lo_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   step_w;

    always_comb begin
      step_w = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mc_q} : {(WIDTH+1){1'b0}});
    end

    assign mul_hi_d = step_w[WIDTH:1];
    assign mul_lo_d = {step_w[0], lo_q[MSB:1]};
    assign mul_last = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
      if (rst) begin
        mc_q  <= '0;
        hi_q  <= '0;
        lo_q  <= '0;
        cnt_q <= '0;
      end else if (accept && is_mul) begin
        mc_q  <= bus.B;
        hi_q  <= '0;
        lo_q  <= bus.A;
        cnt_q <= '0;
      end else if (state_q == S_MUL) begin
        hi_q  <= mul_hi_d;
        lo_q  <= mul_lo_d;
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end else begin : g_no_mul
    assign mul_hi_d = '0;
    assign mul_lo_d = '0;
    assign mul_last = 1'b0;
  end

  // ---------------------------------------------------------------
  // Control FSM with the result and flag registers. Flags and illegal
  // change only on entry to DONE, so ADC/SBC always see the carry from
  // the previously completed op.
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      result_q    <= '0;
      result_hi_q <= '0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      ill_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (is_mul) begin
              state_q <= S_MUL;
            end else begin
              state_q     <= S_DONE;
              result_q    <= alu_r;
              result_hi_q <= '0;
              c_q         <= alu_c;
              v_q         <= alu_v;
              z_q         <= (alu_r == '0);
              n_q         <= alu_r[MSB];
              ill_q       <= alu_ill;
            end
          end
        end
        S_MUL: begin
          if (mul_last) begin
            state_q     <= S_DONE;
            result_q    <= mul_lo_d;
            result_hi_q <= mul_hi_d;
            c_q         <= (mul_hi_d != '0);
            v_q         <= 1'b0;
            z_q         <= ({mul_hi_d, mul_lo_d} == '0);
            n_q         <= mul_hi_d[MSB];
            ill_q       <= 1'b0;
          end
        end
        S_DONE: begin
          if (bus.out_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = result_q;
  assign bus.result_hi = result_hi_q;
  assign bus.C         = c_q;
  assign bus.V         = v_q;
  assign bus.Z         = z_q;
  assign bus.N         = n_q;
  assign bus.illegal   = ill_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq (WIDTH 8, multiplier built). Each result is packed
// as {illegal,C,V,Z,N,result_hi,result}; expected values come from an
// integer reference model and are queued when the op is driven.
module tb_alu_seq;
  localparam int W  = 8;
  localparam int RW = 2 * W + 5;

  logic       clk;
  logic       rst;
  logic [1:0] state_o;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [RW-1:0] exp_q[$];
  logic          m_c = 1'b0;

  function automatic logic [RW-1:0] observed();
    return {bus.illegal, bus.C, bus.V, bus.Z, bus.N, bus.result_hi, bus.result};
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [RW-1:0] model_op(input logic [7:0] op,
                                             input logic [W-1:0] a, b,
                                             input logic cin);
    int maxu, smax, smin, ua, ub, sa, sb, ci, full, s, r, hi;
    longint p;
    logic ill, c, v, z, n;
    maxu = (1 << W) - 1; smax = (1 << (W - 1)) - 1; smin = -(1 << (W - 1));
    ua = a; ub = b; sa = $signed(a); sb = $signed(b); ci = cin;
    r = 0; hi = 0; ill = 0; c = 0; v = 0; s = 0;
    case (op)
      8'h00: begin full = ua + ub; r = full & maxu; c = full > maxu; s = sa + sb; v = s > smax || s < smin; end
      8'h01: begin full = ua - ub; r = full & maxu; c = ua < ub; s = sa - sb; v = s > smax || s < smin; end
      8'h02: r = ua & ub;
      8'h03: r = ua | ub;
      8'h04: r = ua ^ ub;
      8'h05: r = (sa < sb) ? 1 : 0;
      8'h06: begin r = (ub + 1) & maxu; c = ub == maxu; v = sb + 1 > smax; end
      8'h07: begin r = (ub - 1) & maxu; c = ub == 0; v = sb - 1 < smin; end
      8'h08: begin r = (ub << 1) & maxu; c = (ub >> (W - 1)) & 1; end
      8'h09: begin r = ub >> 1; c = ub & 1; end
      8'h0A: begin r = (sb >>> 1) & maxu; c = ub & 1; end
      8'h0B: r = ((ub << 1) | (ub >> (W - 1))) & maxu;
      8'h0C: r = (ub >> 1) | ((ub & 1) << (W - 1));
      8'h0D: begin full = ua + ub + ci; r = full & maxu; c = full > maxu; s = sa + sb + ci; v = s > smax || s < smin; end
      8'h0E: begin full = ua - ub - ci; r = full & maxu; c = full < 0; s = sa - sb - ci; v = s > smax || s < smin; end
      8'h0F: begin
        p = longint'(ua) * longint'(ub);
        hi = int'(p >> W); r = int'(p) & maxu; c = hi != 0;
        z = p == 0; n = ((p >> (2 * W - 1)) & 1) != 0;
        return {1'b0, c, 1'b0, z, n, W'(hi), W'(r)};
      end
      default: ill = 1;
    endcase
    z = r == 0;
    n = ((r >> (W - 1)) & 1) != 0;
    return {ill, c, v, z, n, W'(hi), W'(r)};
  endfunction

  // ---------------- driver tasks ----------------
  // Waits for in_ready, presents one op and returns just after the
  // accepting edge; the expected result is queued at the same time.
  task automatic send_op(input logic [7:0] op, input logic [W-1:0] a, b);
    logic [RW-1:0] e;
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (bus.in_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL send_timeout in_ready=%b required=1", bus.in_ready);
    end
    bus.opcode = op; bus.A = a; bus.B = b; bus.in_valid = 1'b1;
    e = model_op(op, a, b, m_c);
    exp_q.push_back(e);
    m_c = e[RW-2];
    @(posedge clk);
  endtask

  // Waits for out_valid (counting cycles from the accept edge), samples the
  // outputs, stalls 'hold' cycles, then completes the handshake.
  task automatic collect(input int hold, output logic [RW-1:0] obs, output int lat);
    lat = 0;
    obs = 'x;
    do begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat++;
    end while (bus.out_valid !== 1'b1 && lat < 40);
    if (bus.out_valid !== 1'b1) begin
      checks++; failures++;
      $display("FAIL collect_timeout out_valid=%b required=1", bus.out_valid);
    end else begin
      obs = observed();
      repeat (hold) @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.opcode = '0; bus.A = '0; bus.B = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (observed() !== '0) begin
      failures++; $display("FAIL reset_outputs got=%h required=0", observed());
    end
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_handshake in_ready=%b out_valid=%b required=1/0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_add_overflow();
    logic [RW-1:0] obs, e; int lat;
    send_op(8'h00, 8'h7F, 8'h01);
    collect(0, obs, lat);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin failures++; $display("FAIL add_7f_01 got=%h required=%h", obs, e); end
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL add_latency got=%0d required=1", lat); end
  endtask

  task automatic test_carry_chain();
    logic [RW-1:0] obs, e; int lat;
    logic [7:0] ops[4] = '{8'h00, 8'h0D, 8'h01, 8'h0E};
    logic [7:0] as[4]  = '{8'hFF, 8'h00, 8'h00, 8'h05};
    logic [7:0] bs[4]  = '{8'h01, 8'h00, 8'h01, 8'h02};
    for (int i = 0; i < 4; i++) begin
      send_op(ops[i], as[i], bs[i]);
      collect(0, obs, lat);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin failures++; $display("FAIL chain_%0d op=%h got=%h required=%h", i, ops[i], obs, e); end
    end
  endtask

  task automatic test_mul();
    logic [RW-1:0] obs, e; int lat; logic got;
    send_op(8'h0F, 8'hFF, 8'hFF);
    bus.out_ready = 1'b1;  // ignored while out_valid is low
    lat = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid === 1'b1) got = 1'b1;
      else begin
        checks++;
        if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL mul_in_ready cycle=%0d got=%b required=0", lat, bus.in_ready); end
        bus.in_valid = lat[0]; bus.opcode = 8'h00; bus.A = 8'h11; bus.B = 8'h22;
      end
    end
    bus.in_valid = 1'b0;
    obs = observed();
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin failures++; $display("FAIL mul_ff_ff got=%h required=%h", obs, e); end
    checks++;
    if (lat !== W + 1) begin failures++; $display("FAIL mul_latency got=%0d required=%0d", lat, W + 1); end
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL mul_no_extra out_valid=%b in_ready=%b required=0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_shifts();
    logic [RW-1:0] obs, e; int lat;
    logic [7:0] ops[3] = '{8'h0A, 8'h05, 8'h0C};
    logic [7:0] as[3]  = '{8'h00, 8'h80, 8'h00};
    logic [7:0] bs[3]  = '{8'h81, 8'h01, 8'h01};
    for (int i = 0; i < 3; i++) begin
      send_op(ops[i], as[i], bs[i]);
      collect(0, obs, lat);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin failures++; $display("FAIL shift_%0d op=%h got=%h required=%h", i, ops[i], obs, e); end
    end
  endtask

  task automatic test_backpressure();
    logic [RW-1:0] first, e; int n;
    send_op(8'h00, 8'h12, 8'h34);
    n = 0;
    do begin @(negedge clk); bus.in_valid = 1'b0; n++; end
    while (bus.out_valid !== 1'b1 && n < 20);
    first = observed();
    e = exp_q.pop_front();
    checks++;
    if (first !== e) begin failures++; $display("FAIL bp_value got=%h required=%h", first, e); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (observed() !== e || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cycle=%0d got=%h v=%b r=%b required=%h v=1 r=0", i, observed(), bus.out_valid, bus.in_ready, e);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_release out_valid=%b in_ready=%b required=0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset_mid_mul();
    logic [RW-1:0] obs, e; int lat;
    send_op(8'h0F, 8'hA5, 8'h3C);
    repeat (3) @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    m_c = 1'b0;
    checks++;
    if (observed() !== '0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mul_abort got=%h v=%b r=%b required=0 v=0 r=1", observed(), bus.out_valid, bus.in_ready);
    end
    repeat (12) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL mul_abort_late out_valid=%b required=0", bus.out_valid); end
    send_op(8'h20, 8'h5A, 8'hC3);
    collect(0, obs, lat);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin failures++; $display("FAIL illegal_20 got=%h required=%h", obs, e); end
  endtask

  task automatic test_back_to_back();
    logic [RW-1:0] obs, e; int lat, exp_lat;
    logic [7:0] op;
    for (int i = 0; i < 40; i++) begin
      op = 8'($urandom_range(0, 17));
      exp_lat = (op == 8'h0F) ? W + 1 : 1;
      send_op(op, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      collect($urandom_range(0, 2), obs, lat);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin failures++; $display("FAIL rand_%0d op=%h got=%h required=%h", i, op, obs, e); end
      checks++;
      if (lat !== exp_lat) begin failures++; $display("FAIL rand_lat_%0d op=%h got=%0d required=%0d", i, op, lat, exp_lat); end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_add_overflow();
    test_carry_chain();
    test_mul();
    test_shifts();
    test_backpressure();
    test_reset_mid_mul();
    test_back_to_back();
    checks++;
    if (exp_q.size() !== 0) begin failures++; $display("FAIL queue_drain got=%0d required=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule
